// File: rtl/line_sched.sv
// line_sched: queues line commands in a small FIFO and feeds them one at a
// time to the Bresenham drawer, forwarding drawer pixels to the framebuffer.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | nothing in flight, waiting for a queued or incoming command
// S_LOAD  | endpoints presented to drawer, ln_start high unless degenerate
// S_DRAW  | drawer running, pixels forwarded with px_ready as back-pressure
// S_POINT | degenerate line, single pixel (x0,y0) held until accepted
module line_sched #(
    parameter int XY_BITW  = 16,
    parameter int DEPTH    = 4,
    parameter int CNT_BITW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [XY_BITW-1:0]  cmd_x0,
    input  logic [XY_BITW-1:0]  cmd_y0,
    input  logic [XY_BITW-1:0]  cmd_x1,
    input  logic [XY_BITW-1:0]  cmd_y1,
    input  logic                cmd_last,
    input  logic                abort,
    output logic                ln_start,
    output logic                ln_oe,
    output logic [XY_BITW-1:0]  ln_x0,
    output logic [XY_BITW-1:0]  ln_y0,
    output logic [XY_BITW-1:0]  ln_x1,
    output logic [XY_BITW-1:0]  ln_y1,
    input  logic [XY_BITW-1:0]  ln_x,
    input  logic [XY_BITW-1:0]  ln_y,
    input  logic                ln_drawing,
    input  logic                ln_done,
    output logic [XY_BITW-1:0]  px_x,
    output logic [XY_BITW-1:0]  px_y,
    output logic                px_valid,
    input  logic                px_ready,
    output logic                busy,
    output logic                shape_done,
    output logic [CNT_BITW-1:0] lines_drawn
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 4 * XY_BITW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_POINT} state_t;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    state_t              state_q, state_d;
    logic                ln_start_q, ln_start_d;
    logic                last_q, last_d, degen_q, degen_d;
    logic [XY_BITW-1:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CNT_BITW-1:0] lines_q, lines_d;

    logic                full, empty, push, pop, complete, enter_load;
    logic [EW-1:0]       in_entry, head, src;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push     = cmd_valid && !full && !abort;
    assign pop      = (state_q == S_LOAD) && !abort;
    assign in_entry = {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_last};
    assign head     = mem_q[rd_ptr_q];
    assign complete = ((state_q == S_DRAW) && ln_done && px_ready) ||
                      ((state_q == S_POINT) && px_ready);

    // FIFO pointers and occupancy; abort empties the queue outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Sequencer: endpoints are captured on entry to LOAD so they are already
    // valid in the same cycle as ln_start. From IDLE an empty FIFO means the
    // command being pushed right now is the one to load.
    always_comb begin
        state_d    = state_q;
        ln_start_d = 1'b0;
        last_d     = last_q;
        degen_d    = degen_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        lines_d    = lines_q;
        shape_done = 1'b0;
        enter_load = 1'b0;
        src        = empty ? in_entry : head;
        case (state_q)
            S_IDLE:  enter_load = !empty || push;
            S_LOAD:  state_d = degen_q ? S_POINT : S_DRAW;
            S_DRAW, S_POINT: begin
                if (complete) begin
                    lines_d    = lines_q + CNT_BITW'(1);
                    shape_done = last_q;
                    if (!empty) enter_load = 1'b1;
                    else        state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_load && !abort) begin
            state_d = S_LOAD;
            {x0_d, y0_d, x1_d, y1_d, last_d} = src;
            degen_d    = (x0_d == x1_d) && (y0_d == y1_d);
            ln_start_d = !degen_d;
        end
        if (abort) begin
            state_d    = S_IDLE;
            ln_start_d = 1'b0;
            lines_d    = lines_q;
            shape_done = 1'b0;
        end
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ln_start_q <= 1'b0;
            last_q     <= 1'b0;
            degen_q    <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            lines_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ln_start_q <= ln_start_d;
            last_q     <= last_d;
            degen_q    <= degen_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            lines_q    <= lines_d;
        end
    end

    // FIFO storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign cmd_ready   = !full;
    assign ln_start    = ln_start_q;
    assign ln_oe       = (state_q == S_DRAW) && px_ready;
    assign ln_x0       = x0_q;
    assign ln_y0       = y0_q;
    assign ln_x1       = x1_q;
    assign ln_y1       = y1_q;
    assign px_valid    = (state_q == S_DRAW) ? (ln_drawing || ln_done) : (state_q == S_POINT);
    assign px_x        = (state_q == S_POINT) ? x0_q : ln_x;
    assign px_y        = (state_q == S_POINT) ? y0_q : ln_y;
    assign busy        = (state_q != S_IDLE) || !empty;
    assign lines_drawn = lines_q;

endmodule

// File: tb/tb_line_sched.sv
// Bench for line_sched: a behavioural Bresenham drawer answers ln_start, and a
// reference model tracks the expected pixel stream, counters and flags.
module tb_line_sched;
    localparam int XW    = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_last = 1'b0, abort = 1'b0, px_ready = 1'b0;
    logic [XW-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic cmd_ready, ln_start, ln_oe, px_valid, busy, shape_done;
    logic [XW-1:0] ln_x0, ln_y0, ln_x1, ln_y1, ln_x, ln_y, px_x, px_y;
    logic ln_drawing, ln_done;
    logic [CNT_W-1:0] lines_drawn;

    int n_test = 0;
    int n_fail = 0;

    line_sched #(.XY_BITW(XW), .DEPTH(DEPTH), .CNT_BITW(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_last(cmd_last), .abort(abort),
        .ln_start(ln_start), .ln_oe(ln_oe),
        .ln_x0(ln_x0), .ln_y0(ln_y0), .ln_x1(ln_x1), .ln_y1(ln_y1),
        .ln_x(ln_x), .ln_y(ln_y), .ln_drawing(ln_drawing), .ln_done(ln_done),
        .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .px_ready(px_ready),
        .busy(busy), .shape_done(shape_done), .lines_drawn(lines_drawn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bresenham point count and k-th point (x*256+y)
    function automatic int bres_n(input int x0, input int y0, input int x1, input int y1);
        int dx, dy;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y1 - y0 : y0 - y1;
        return ((dx > dy) ? dx : dy) + 1;
    endfunction

    function automatic int bres_xy(input int x0, input int y0, input int x1, input int y1, input int k);
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        for (int i = 0; i < k; i++) begin
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        return x * 256 + y;
    endfunction

    // Drawer model: latches endpoints on ln_start, advances on ln_oe
    bit d_run = 1'b0;
    int d_idx = 0, d_n = 1, dx0 = 0, dy0 = 0, dx1 = 0, dy1 = 0;
    int d_p;
    assign d_p        = bres_xy(dx0, dy0, dx1, dy1, d_idx);
    assign ln_x       = d_p[15:8];
    assign ln_y       = d_p[7:0];
    assign ln_drawing = d_run;
    assign ln_done    = d_run && (d_idx == d_n - 1);

    always @(posedge clk) begin
        if (rst) begin
            d_run <= 1'b0;
        end else if (ln_start) begin
            dx0   <= int'(ln_x0);
            dy0   <= int'(ln_y0);
            dx1   <= int'(ln_x1);
            dy1   <= int'(ln_y1);
            d_idx <= 0;
            d_n   <= bres_n(int'(ln_x0), int'(ln_y0), int'(ln_x1), int'(ln_y1));
            d_run <= 1'b1;
        end else if (d_run && ln_oe) begin
            if (d_idx == d_n - 1) d_run <= 1'b0;
            else                  d_idx <= d_idx + 1;
        end
    end

    // Reference model: queue of accepted commands and their expected pixels
    typedef struct {int x0; int y0; int x1; int y1; bit last;} cmd_t;
    typedef struct {int x; int y; bit endl; bit shape;} pt_t;
    cmd_t cq[$];
    pt_t  pq[$];
    int   m_out = 0, m_cnt = 0;
    bit   m_active = 1'b0;

    always @(negedge clk) begin
        cmd_t c;
        pt_t  p;
        int   n, xy, exp_shape;
        bit   start_now;
        if (rst) begin
            cq.delete();
            pq.delete();
            m_out = 0;
            m_cnt = 0;
            m_active = 1'b0;
        end else begin
            chk("lines_drawn", int'(lines_drawn), m_cnt);
            chk("busy", int'(busy), int'(m_out != 0));
            if (m_out < DEPTH) chk("cmd_ready_free", int'(cmd_ready), 1);
            if (m_out > DEPTH) chk("cmd_ready_full", int'(cmd_ready), 0);
            chk("ln_oe", int'(ln_oe), m_active ? int'(px_ready) : 0);
            if (m_out == 0) chk("px_valid_idle", int'(px_valid), 0);
            exp_shape = 0;
            start_now = 1'b0;
            if (ln_start) begin
                start_now = 1'b1;
                chk("start_while_active", int'(m_active), 0);
                chk("start_queue", int'(cq.size() > 0), 1);
                if (cq.size() > 0) begin
                    c = cq[0];
                    chk("start_degenerate", int'(c.x0 == c.x1 && c.y0 == c.y1), 0);
                    chk("ln_x0", int'(ln_x0), c.x0);
                    chk("ln_y0", int'(ln_y0), c.y0);
                    chk("ln_x1", int'(ln_x1), c.x1);
                    chk("ln_y1", int'(ln_y1), c.y1);
                end
            end
            if (!abort && px_valid && px_ready) begin
                chk("px_queue", int'(pq.size() > 0), 1);
                if (pq.size() > 0) begin
                    p = pq.pop_front();
                    chk("px_x", int'(px_x), p.x);
                    chk("px_y", int'(px_y), p.y);
                    if (p.endl) begin
                        m_cnt    = (m_cnt + 1) % (1 << CNT_W);
                        m_out    = m_out - 1;
                        m_active = 1'b0;
                        if (cq.size() > 0) void'(cq.pop_front());
                        exp_shape = int'(p.shape);
                    end
                end
            end
            chk("shape_done", int'(shape_done), exp_shape);
            if (start_now && !abort) m_active = 1'b1;
            if (abort) begin
                cq.delete();
                pq.delete();
                m_out = 0;
                m_active = 1'b0;
            end else if (cmd_valid && cmd_ready) begin
                c = '{int'(cmd_x0), int'(cmd_y0), int'(cmd_x1), int'(cmd_y1), cmd_last};
                cq.push_back(c);
                m_out = m_out + 1;
                n = bres_n(c.x0, c.y0, c.x1, c.y1);
                for (int k = 0; k < n; k++) begin
                    xy = bres_xy(c.x0, c.y0, c.x1, c.y1, k);
                    pq.push_back('{xy / 256, xy % 256, k == n - 1, c.last});
                end
            end
        end
    end

    task automatic push_cmd(input int x0, input int y0, input int x1, input int y1, input bit last);
        bit ok;
        ok = 1'b0;
        cmd_x0 = XW'(x0); cmd_y0 = XW'(y0); cmd_x1 = XW'(x1); cmd_y1 = XW'(y1);
        cmd_last = last;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        if (!ok) chk("push_timeout", int'(cmd_ready), 1);
    endtask

    // mode 0: px_ready held high, mode 1: px_ready toggles each cycle
    task automatic run_idle(input int mode, input int budget, output int npix, output int lx,
                            output int ly, output int nshape, output int nstart, output int nbub);
        bit done;
        int prev_ld;
        npix = 0; lx = -1; ly = -1; nshape = 0; nstart = 0; nbub = 0;
        done = 1'b0;
        prev_ld = int'(lines_drawn);
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            px_ready = (mode == 0) ? 1'b1 : 1'(i % 2);
            #1;
            if (px_valid && px_ready) begin npix++; lx = int'(px_x); ly = int'(px_y); end
            if (shape_done) nshape++;
            if (ln_start) begin
                nstart++;
                if (int'(lines_drawn) != prev_ld) nbub++;
            end
            prev_ld = int'(lines_drawn);
            if (!busy) done = 1'b1;
        end
        if (!done) chk("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        int np, lx, ly, ns, nst, nb;
        int rx0, ry0, rx1, ry1;

        chk("pin_bres_n", bres_n(0, 0, 3, 1), 4);
        chk("pin_bres_pt", bres_xy(0, 0, 3, 1, 2), 2 * 256 + 1);
        chk("pin_bres_diag", bres_xy(0, 0, 5, 5, 3), 3 * 256 + 3);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_lines", int'(lines_drawn), 0);
        chk("rst_px_valid", int'(px_valid), 0);
        chk("rst_ln_start", int'(ln_start), 0);
        chk("rst_ln_x1", int'(ln_x1), 0);

        // single line
        px_ready = 1'b1;
        push_cmd(0, 0, 3, 1, 1'b1);
        #1 chk("t1_start_latency", int'(ln_start), 1);
        run_idle(0, 50, np, lx, ly, ns, nst, nb);
        chk("t1_npix", np, 4);
        chk("t1_last_x", lx, 3);
        chk("t1_last_y", ly, 1);
        chk("t1_shape", ns, 1);
        chk("t1_lines", int'(lines_drawn), 1);

        // degenerate point
        push_cmd(7, 9, 7, 9, 1'b0);
        #1 chk("t3_no_start_load", int'(ln_start), 0);
        run_idle(0, 50, np, lx, ly, ns, nst, nb);
        chk("t3_npix", np, 1);
        chk("t3_x", lx, 7);
        chk("t3_y", ly, 9);
        chk("t3_no_start", nst, 0);
        chk("t3_lines", int'(lines_drawn), 2);

        // back-pressure toggling
        push_cmd(0, 0, 5, 5, 1'b0);
        run_idle(1, 100, np, lx, ly, ns, nst, nb);
        chk("t4_npix", np, 6);
        chk("t4_last_x", lx, 5);
        chk("t4_last_y", ly, 5);
        chk("t4_lines", int'(lines_drawn), 3);

        // fill the queue behind a stalled line
        px_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_cmd(0, k, 4, k, 1'b0);
        #1;
        chk("t2_full_ready", int'(cmd_ready), 0);
        chk("t2_busy", int'(busy), 1);
        run_idle(0, 200, np, lx, ly, ns, nst, nb);
        chk("t2_npix", np, 25);
        chk("t2_starts", nst, 4);
        chk("t2_bubbles", nb, 4);
        chk("t2_lines", int'(lines_drawn), 8);

        // abort mid-line with queued commands
        px_ready = 1'b1;
        for (int k = 0; k < 3; k++) push_cmd(0, 0, 20, 0, 1'b1);
        @(posedge clk); #1;
        abort = 1'b1;
        cmd_x0 = 8'd3; cmd_y0 = 8'd3; cmd_x1 = 8'd6; cmd_y1 = 8'd6; cmd_last = 1'b1;
        cmd_valid = 1'b1;
        #1 chk("t5_abort_shape", int'(shape_done), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_px_valid", int'(px_valid), 0);
        chk("t5_lines", int'(lines_drawn), 8);
        @(posedge clk); #2;
        chk("t5_discarded", int'(busy), 0);
        push_cmd(1, 1, 2, 2, 1'b1);
        run_idle(0, 50, np, lx, ly, ns, nst, nb);
        chk("t5_npix", np, 2);
        chk("t5_shape", ns, 1);
        chk("t5_lines_after", int'(lines_drawn), 9);

        // reset during DRAW
        push_cmd(0, 0, 10, 3, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("t6_lines", int'(lines_drawn), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_px_valid", int'(px_valid), 0);
        chk("t6_ln_start", int'(ln_start), 0);
        chk("t6_ln_x1", int'(ln_x1), 0);
        chk("t6_ln_y1", int'(ln_y1), 0);
        chk("t6_cmd_ready", int'(cmd_ready), 1);
        push_cmd(2, 2, 4, 3, 1'b1);
        run_idle(0, 50, np, lx, ly, ns, nst, nb);
        chk("t6_npix", np, 3);
        chk("t6_last_x", lx, 4);
        chk("t6_last_y", ly, 3);
        chk("t6_lines_after", int'(lines_drawn), 1);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rx0 = int'($urandom_range(15));
            ry0 = int'($urandom_range(15));
            rx1 = int'($urandom_range(15));
            ry1 = int'($urandom_range(15));
            if ($urandom_range(7) == 0) begin rx1 = rx0; ry1 = ry0; end
            cmd_x0 = XW'(rx0); cmd_y0 = XW'(ry0); cmd_x1 = XW'(rx1); cmd_y1 = XW'(ry1);
            cmd_last  = 1'($urandom_range(1));
            cmd_valid = ($urandom_range(2) == 0);
            px_ready  = ($urandom_range(9) < 7);
            abort     = ($urandom_range(199) == 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        abort = 1'b0;
        run_idle(0, 3000, np, lx, ly, ns, nst, nb);
        chk("drain_queue_empty", pq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
